// File: rtl/sdtc_pe.sv
// Pipelined integer dot-product PE: N_MUL signed multiplies, registered adder tree,
// multi-beat accumulation with sticky signed-overflow, optional 2:4 sparse B select.

module sdtc_pe_lane #(
  parameter int DW_IN = 8
) (
  input  logic [DW_IN-1:0]          a_i,
  input  logic [DW_IN-1:0]          b_dense_i,
  input  logic [4*DW_IN-1:0]        b_grp_i,
  input  logic [1:0]                idx_i,
  input  logic                      sparse_i,
  output logic signed [2*DW_IN-1:0] prod_o
);
  localparam int PW = 2*DW_IN;

  logic [DW_IN-1:0] b_sp, b_sel;

  assign b_sp   = b_grp_i[DW_IN*int'(idx_i) +: DW_IN];
  assign b_sel  = sparse_i ? b_sp : b_dense_i;
  assign prod_o = PW'($signed(a_i)) * PW'($signed(b_sel));
endmodule

module sdtc_pe #(
  parameter int N_MUL  = 8,
  parameter int DW_IN  = 8,
  parameter int DW_ACC = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [N_MUL*DW_IN-1:0]    in_a_i,
  input  logic [2*N_MUL*DW_IN-1:0]  in_b_i,
  input  logic [2*N_MUL-1:0]        in_idx_i,
  input  logic                      in_sparse_i,
  input  logic                      in_first_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DW_ACC-1:0]         out_o,
  output logic                      out_ovf_o
);
  localparam int LG     = $clog2(N_MUL);
  localparam int PW     = 2*DW_IN;
  localparam int TW     = PW + LG;
  localparam int STAGES = LG + 1;
  localparam int EW     = (DW_ACC > TW) ? DW_ACC : TW;
  localparam int NN     = 2*N_MUL - 1;

  logic                stall;
  logic [STAGES:0]     vld_pipe;
  logic [LG:0]         first_pipe;
  logic [STAGES:0]     last_pipe;
  logic signed [PW-1:0] prod [N_MUL];
  // Heap-ordered tree: node n sums children 2n+1/2n+2, leaves hold products.
  logic signed [TW-1:0] node_q [NN];
  logic signed [EW-1:0] sum_w;
  logic [DW_ACC-1:0]   sum_a, acc_add, acc_d, acc_q, out_q;
  logic                ovf_add, ovf_d, ovf_q, out_ovf_q, out_valid_q;

  assign stall       = out_valid_q & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign out_ovf_o   = out_ovf_q;

  for (genvar i = 0; i < N_MUL; i++) begin : g_lane
    sdtc_pe_lane #(.DW_IN(DW_IN)) u_lane (
      .a_i       (in_a_i[DW_IN*i +: DW_IN]),
      .b_dense_i (in_b_i[DW_IN*i +: DW_IN]),
      .b_grp_i   (in_b_i[4*DW_IN*(i/2) +: 4*DW_IN]),
      .idx_i     (in_idx_i[2*i +: 2]),
      .sparse_i  (in_sparse_i),
      .prod_o    (prod[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NN; n++) node_q[n] <= '0;
    end else if (!stall) begin
      for (int n = 0; n < N_MUL-1; n++) node_q[n] <= node_q[2*n+1] + node_q[2*n+2];
      for (int i = 0; i < N_MUL; i++) node_q[N_MUL-1+i] <= TW'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else if (!stall) begin
      vld_pipe   <= {vld_pipe[STAGES-1:0], in_valid_i};
      first_pipe <= {first_pipe[LG-1:0], in_first_i};
      last_pipe  <= {last_pipe[STAGES-1:0], in_last_i};
    end
  end

  // Narrow accumulators truncate the tree sum; wrap and overflow follow from that.
  assign sum_w   = EW'(node_q[0]);
  assign sum_a   = sum_w[DW_ACC-1:0];
  assign acc_add = acc_q + sum_a;
  assign ovf_add = (acc_q[DW_ACC-1] == sum_a[DW_ACC-1]) &&
                   (acc_add[DW_ACC-1] != acc_q[DW_ACC-1]);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (vld_pipe[LG]) begin
      if (first_pipe[LG]) begin
        acc_d = sum_a;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_add;
        ovf_d = ovf_q | ovf_add;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= vld_pipe[STAGES] & last_pipe[STAGES];
      if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
        out_q     <= acc_q;
        out_ovf_q <= ovf_q;
      end
    end
  end
endmodule

// File: tb/tb_sdtc_pe.sv
// Randomized and directed bench for sdtc_pe; two instances (32-bit and 18-bit
// accumulators) share stimulus and are scored against an in-order group model.

module tb_sdtc_pe;
  localparam int N  = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_sparse = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [N*DW-1:0]   in_a = '0;
  logic [2*N*DW-1:0] in_b = '0;
  logic [2*N-1:0]    in_idx = '0;
  logic rdy32, ov32, ovf32, rdy18, ov18, ovf18;
  logic [31:0] out32;
  logic [17:0] out18;

  sdtc_pe #(.N_MUL(N), .DW_IN(DW), .DW_ACC(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .in_a_i(in_a), .in_b_i(in_b), .in_idx_i(in_idx), .in_sparse_i(in_sparse),
    .in_first_i(in_first), .in_last_i(in_last), .out_valid_o(ov32),
    .out_ready_i(out_ready), .out_o(out32), .out_ovf_o(ovf32));

  sdtc_pe #(.N_MUL(N), .DW_IN(DW), .DW_ACC(18)) u18 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy18),
    .in_a_i(in_a), .in_b_i(in_b), .in_idx_i(in_idx), .in_sparse_i(in_sparse),
    .in_first_i(in_first), .in_last_i(in_last), .out_valid_o(ov18),
    .out_ready_i(out_ready), .out_o(out18), .out_ovf_o(ovf18));

  always #5 clk = ~clk;

  typedef struct { longint v; bit o; } exp_t;
  exp_t   q32[$], q18[$];
  int     ncmp = 0, nerr = 0;
  int     ta[N], tbv[2*N], tidx[N];
  longint macc[2];
  bit     movf[2];
  bit     stop_rnd;

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    longint m = (64'sd1 <<< w) - 1;
    longint r = v & m;
    if (r[w-1]) r = r - (64'sd1 <<< w);
    return r;
  endfunction

  // Group model: exact dot product, then wrap to each accumulator width.
  task automatic model_beat(input bit f, input bit l, input bit sp);
    longint s = 0, st, ex;
    int w;
    exp_t e;
    for (int i = 0; i < N; i++)
      s += longint'(ta[i]) * longint'(sp ? tbv[4*(i/2) + tidx[i]] : tbv[i]);
    for (int d = 0; d < 2; d++) begin
      w  = (d == 0) ? 32 : 18;
      st = sx(s, w);
      if (f) begin
        macc[d] = st;
        movf[d] = 1'b0;
      end else begin
        ex = macc[d] + st;
        if (ex > (64'sd1 <<< (w-1)) - 1 || ex < -(64'sd1 <<< (w-1))) movf[d] = 1'b1;
        macc[d] = sx(ex, w);
      end
      if (l) begin
        e.v = macc[d] & ((64'sd1 <<< w) - 1);
        e.o = movf[d];
        if (d == 0) q32.push_back(e); else q18.push_back(e);
      end
    end
  endtask

  task automatic send(input bit f, input bit l, input bit sp);
    int n = 0;
    for (int i = 0; i < N; i++) begin
      in_a[DW*i +: DW]  = DW'(ta[i]);
      in_idx[2*i +: 2]  = 2'(tidx[i]);
    end
    for (int j = 0; j < 2*N; j++) in_b[DW*j +: DW] = DW'(tbv[j]);
    in_sparse = sp; in_first = f; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!rdy32 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_tmo", rdy32, 1);
    @(posedge clk);
    model_beat(f, l, sp);
    #1 in_valid = 1'b0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ta[i]   = int'($urandom_range(0, 255)) - 128;
      tidx[i] = int'($urandom_range(0, 3));
    end
    for (int j = 0; j < 2*N; j++) tbv[j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic set_ops(input int av, input int bv);
    for (int i = 0; i < N; i++) begin ta[i] = av; tidx[i] = 0; end
    for (int j = 0; j < 2*N; j++) tbv[j] = bv;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q18.size() != 0) && n < 400) begin @(posedge clk); n++; end
    chk("drain32", q32.size(), 0);
    chk("drain18", q18.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output scoreboard and handshake/stability checks, sampled mid-cycle.
  bit prev_hold;
  logic [31:0] prev32;
  logic [17:0] prev18;
  logic prevo32, prevo18;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      chk("in_ready32", rdy32, !(ov32 && !out_ready));
      chk("in_ready18", rdy18, !(ov18 && !out_ready));
      if (prev_hold) begin
        chk("stable_out32", out32, prev32);
        chk("stable_out18", out18, prev18);
        chk("stable_ovf32", ovf32, prevo32);
        chk("stable_ovf18", ovf18, prevo18);
      end
      if (ov32 && out_ready) begin
        chk("result32_expected", q32.size() != 0, 1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          chk("out32", out32, e.v);
          chk("ovf32", ovf32, e.o);
        end
      end
      if (ov18 && out_ready) begin
        chk("result18_expected", q18.size() != 0, 1);
        if (q18.size() != 0) begin
          e = q18.pop_front();
          chk("out18", out18, e.v);
          chk("ovf18", ovf18, e.o);
        end
      end
      prev_hold = ov32 && !out_ready;
      prev32 = out32; prev18 = out18; prevo32 = ovf32; prevo18 = ovf18;
    end
  end

  initial begin
    int len, n;
    bit nf;
    macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
    #2;
    chk("rst_in_ready", rdy32, 1);
    chk("rst_out_valid", ov32, 0);
    chk("rst_out", out32, 0);
    chk("rst_ovf", ovf32, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Dense single beat with latency check
    for (int i = 0; i < N; i++) begin ta[i] = i + 1; tbv[i] = i + 1; tidx[i] = 0; end
    for (int j = N; j < 2*N; j++) tbv[j] = 0;
    send(1, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("latency_ov", ov32, k == 5);
    end
    drain();

    // Sparse beat, index pairs (0,3)
    for (int i = 0; i < N; i++) begin ta[i] = 2; tidx[i] = (i % 2) ? 3 : 0; end
    for (int j = 0; j < 2*N; j++) tbv[j] = j;
    send(1, 1, 1);
    drain();

    // Four-beat group with a bubble between beats 2 and 3
    set_ops(1, -1);
    send(1, 0, 0);
    send(0, 0, 0);
    @(posedge clk); #1;
    send(0, 0, 0);
    send(0, 1, 0);
    drain();

    // Overflow on the narrow accumulator, then sticky cleared by next first beat
    set_ops(-128, -128);
    send(1, 0, 0);
    send(0, 1, 0);
    set_ops(1, 1);
    send(1, 1, 0);
    drain();

    // Backpressure: six single-beat groups, out_ready low 4 cycles after first result
    fork
      begin
        for (int g = 0; g < 6; g++) begin rand_ops(); send(1, 1, g % 2); end
      end
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ov32 && n < 100);
        chk("bp_first_result", ov32, 1);
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random groups, bubbles, random backpressure
    stop_rnd = 1'b0;
    fork
      begin
        for (int g = 0; g < 60; g++) begin
          len = int'($urandom_range(1, 4));
          nf  = ($urandom_range(0, 9) == 0);
          for (int k = 0; k < len; k++) begin
            rand_ops();
            send((k == 0) && !nf, k == len - 1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          end
        end
        stop_rnd = 1'b1;
      end
      begin
        while (!stop_rnd) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Known non-zero result, then reset mid-group
    set_ops(3, 5);
    send(1, 1, 0);
    drain();
    rand_ops();
    send(1, 0, 0);
    send(0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov32, 0);
    chk("midrst_out32", out32, 0);
    chk("midrst_out18", out18, 0);
    chk("midrst_ovf18", ovf18, 0);
    chk("midrst_in_ready", rdy32, 1);
    q32.delete(); q18.delete();
    macc[0] = 0; macc[1] = 0; movf[0] = 0; movf[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_ops();
    send(1, 1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
